fb_write_arbiter: RTL
=====================

Name: fb_write_arbiter

Overview:
- Shares one framebuffer write port (addr/data/en into framebuffer_master) between NUM_REQ pixel producers: sprite_driver lanes, a background/road filler and a clear engine.
- Uses round-robin arbitration with bounded bursts and a valid/ready handshake per requester.
- Stalls all writers while the framebuffer is resetting.
- Sits between the renderers and framebuffer_master in top, clocked by the pixel clock.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 19, framebuffer pixel address width.
- DATA_W, 4, colour-index width.
- BURST_MAX, 16, max consecutive beats per grant before re-arbitration (1..255).
- FB_PIXELS, 307200, valid address range is 0..FB_PIXELS-1.

Ports:
- clock  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- fb_resetting  in  1  framebuffer clear in progress; no writes allowed.
- frame_start  in  1  one-cycle pulse at start of vsync.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed colour indices, same packing.
- req_ready  out  NUM_REQ  per-requester beat accept.
- wr_addr  out  ADDR_W  framebuffer write address.
- wr_data  out  DATA_W  framebuffer write data.
- wr_en  out  1  framebuffer write strobe.
- grant_id  out  $clog2(NUM_REQ)  currently/last granted requester.
- busy  out  1  high in GRANT state.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, grant_id=0, req_ready=0, busy=0, state=IDLE, beat_cnt=0, rr pointer set so requester 0 has top priority.
- States: IDLE, GRANT, HOLD.
- IDLE:
  - if fb_resetting -> HOLD.
  - else if any req_valid: pick the first valid requester at or after the rr pointer (wrapping), register grant_id, -> GRANT next cycle.
  - No beat is accepted in IDLE, so arbitration costs 1 cycle.
- GRANT:
  - req_ready[grant_id] is combinational: 1 iff state==GRANT && !fb_resetting. All other ready bits are 0.
  - A beat transfers when req_valid && req_ready.
  - On a beat: beat_cnt++. Next cycle: wr_addr/wr_data = the beat's addr/data and wr_en=1. Write latency is exactly 1 cycle.
  - Out-of-range beat (addr >= FB_PIXELS): accepted (ready still 1), but wr_en stays 0 for it.
  - Leave GRANT when the granted valid is low, or when a beat makes beat_cnt reach BURST_MAX. Then: rr pointer = grant_id+1 mod NUM_REQ, beat_cnt=0, -> IDLE.
  - If fb_resetting rises: -> HOLD immediately. Ready drops combinationally that cycle, so no beat is lost.
- HOLD:
  - All ready=0, wr_en=0.
  - When fb_resetting falls -> IDLE. The rr pointer is preserved and the interrupted requester is re-arbitrated normally.
- frame_start pulse: rr pointer reset to 0; a burst in progress is not cut.
  - If frame_start coincides with end-of-burst, the frame_start pointer value (0) wins.
- wr_en is never 1 in a cycle where fb_resetting was 1 in the previous cycle.
- Single requester continuously valid: BURST_MAX beats, 1 idle cycle, repeat. Throughput is BURST_MAX/(BURST_MAX+1).
- Non-granted requesters must hold valid/addr/data stable until they receive ready.
- NUM_REQ not a power of 2: the pointer wraps at NUM_REQ, not 2^width.

Optional Feature:
- Macro: FB_ARB_STATS_EN.
- Defined:
  - Adds output stat_drops (16 bits): count of out-of-range beats, saturating.
  - Adds output stat_beats (20 bits): count of wr_en pulses in the previous frame.
  - stat_beats is latched and its counter cleared on frame_start.
  - Both reset to 0.
- Undefined: neither port exists and no counters are synthesised. Functional behaviour is otherwise identical.

Decomposition:
- Shared package fb_pkg:
  - FB_WIDTH=640, FB_HEIGHT=480, FB_PIXELS, FB_ADDR_W=19, COLOR_W=4.
  - typedef fb_arb_state_t enum {IDLE, GRANT, HOLD}.
- One sub-module: rr_pick.
  - Purely combinational round-robin priority picker.
  - Inputs: req vector, pointer. Outputs: found, index.
  - Reusable for the sprite queue scheduler.

Test Plan:
- Reset then requester 1 valid with addr=100, data=5 for 1 beat -> ready[1] in cycle 2, then wr_en=1, wr_addr=100, wr_data=5 in cycle 3. grant_id=1.
- BURST_MAX=4, requesters 0 and 2 both always valid -> write order 0,0,0,0, gap, 2,2,2,2, gap, 0…; no beat dropped or duplicated.
- Requester 0 beat addr=307200 -> ready=1, wr_en stays 0. With FB_ARB_STATS_EN, stat_drops=1.
- fb_resetting asserted mid-burst after beat 2 -> ready drops the same cycle and wr_en=0 throughout. After it falls, the burst resumes via IDLE with the remaining data intact.
- Pointer at 2, frame_start pulse, then requesters 1 and 2 valid -> requester 1 granted first.
- Reset asserted mid-GRANT -> next cycle all outputs at reset values and state=IDLE.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry constants and the write-arbiter state type.
package fb_pkg;
    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W = 19;
    localparam int COLOR_W   = 4;
    typedef enum logic [1:0] {IDLE, GRANT, HOLD} fb_arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit at or after ptr (wrapping at N).
// Ports: req (request vector), ptr (highest-priority index), found (any request), index (winner).
module rr_pick #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] index
);
    logic [2*N-1:0] dbl;
    always_comb begin
        // rotate so bit k is requester (ptr+k) mod N; scan high to low so the lowest k wins
        dbl   = {req, req} >> ptr;
        found = 1'b0;
        index = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (dbl[k]) begin
                found = 1'b1;
                index = W'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin, burst-bounded arbiter sharing one framebuffer write port.
// Ports: clock/reset (sync, active-high); fb_resetting stalls all writers; frame_start resets
// the round-robin pointer; req_valid/req_addr/req_data/req_ready per requester (packed i*W);
// wr_addr/wr_data/wr_en registered write port; grant_id current/last grant; busy in GRANT.
// Optional macro FB_ARB_STATS_EN adds stat_drops (out-of-range beats, saturating) and
// stat_beats (write pulses in the previous frame).
module fb_write_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 4,
    parameter int BURST_MAX = 16,
    parameter int FB_PIXELS = 307200,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      fb_resetting,
    input  logic                      frame_start,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      wr_en,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]               stat_drops,
    output logic [19:0]               stat_beats
`endif
);
    import fb_pkg::*;

    fb_arb_state_t     state, state_n;
    logic [ID_W-1:0]   ptr, ptr_n, gid_n, pick, gid_next;
    logic [7:0]        cnt, cnt_n;
    logic              found, beat, in_range, last;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;

    rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .found (found),
        .index (pick)
    );

    assign cur_addr  = req_addr[int'(grant_id) * ADDR_W +: ADDR_W];
    assign cur_data  = req_data[int'(grant_id) * DATA_W +: DATA_W];
    // ready falls combinationally with fb_resetting so no beat is accepted during a clear
    assign req_ready = (state == GRANT && !fb_resetting) ? NUM_REQ'(1) << grant_id : '0;
    assign beat      = |(req_valid & req_ready);
    assign in_range  = 32'(cur_addr) < FB_PIXELS;
    assign last      = cnt == 8'(BURST_MAX - 1);
    assign gid_next  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign busy      = state == GRANT;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gid_n   = grant_id;
        cnt_n   = cnt;
        if (state == HOLD) begin
            state_n = fb_resetting ? HOLD : IDLE;
        end else if (state == IDLE) begin
            if (fb_resetting) begin
                state_n = HOLD;
            end else if (found) begin
                state_n = GRANT;
                gid_n   = pick;
            end
        end else begin
            if (fb_resetting) begin
                state_n = HOLD;
                cnt_n   = '0;
            end else if (!req_valid[grant_id] || last) begin
                state_n = IDLE;
                ptr_n   = gid_next;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
        // frame start overrides any end-of-burst pointer update
        if (frame_start) ptr_n = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
            cnt      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            grant_id <= gid_n;
            cnt      <= cnt_n;
            wr_en    <= beat && in_range;
            if (beat) begin
                wr_addr <= cur_addr;
                wr_data <= cur_data;
            end
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [19:0] frame_beats;
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_drops  <= '0;
            stat_beats  <= '0;
            frame_beats <= '0;
        end else begin
            if (beat && !in_range && stat_drops != 16'hffff) stat_drops <= stat_drops + 1'b1;
            // a pulse coinciding with frame_start still belongs to the closing frame
            if (frame_start) begin
                stat_beats  <= frame_beats + 20'(wr_en);
                frame_beats <= '0;
            end else begin
                frame_beats <= frame_beats + 20'(wr_en);
            end
        end
    end
`endif
endmodule
